oam_dma_ctrl: RTL and testbench

//  Sprite-DMA bus master that shares the external 6502 bus with the core. A CPU write to PAGE_REG

---
 rtl/oam_dma_ctrl_pkg.sv | 22 ++
 rtl/oam_dma_ctrl_counter.sv | 25 ++
 rtl/oam_dma_ctrl.sv | 108 ++++++++++
 tb/tb_oam_dma_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the sprite-DMA controller: FSM state encoding,
// default register addresses and burst length.
package oam_dma_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] PAGE_REG_DEFAULT = 16'h4014;
  localparam logic [15:0] DST_ADDR_DEFAULT = 16'h2004;
  localparam int          XFER_LEN_DEFAULT = 256;

  // One extra bit so the count can represent the full burst length.
  function automatic int idx_width(input int len);
    return $clog2(len) + 1;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_counter.sv
// Byte index counter for the DMA burst: synchronous clear, increment enable
// and a terminal-count flag when the index reaches LEN-1.
module dma_byte_counter #(
  parameter int LEN = 256,
  parameter int W   = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         terminal
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == W'(LEN - 1));

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA bus master: halts the 6502 core via RDY, copies a page of bytes
// to a fixed destination register, then hands the bus back to the core.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter logic [15:0] PAGE_REG = PAGE_REG_DEFAULT,
  parameter logic [15:0] DST_ADDR = DST_ADDR_DEFAULT,
  parameter int          XFER_LEN = XFER_LEN_DEFAULT
) (
  input  logic        PHI0,
  input  logic        RES,
  input  logic [15:0] CPU_A,
  input  logic        CPU_RnW,
  input  logic [7:0]  CPU_DO,
  output logic [7:0]  CPU_DI,
  output logic        RDY,
  output logic [15:0] BUS_A,
  output logic        BUS_RnW,
  output logic [7:0]  BUS_DO,
  input  logic [7:0]  BUS_DI,
  output logic        DMA_BUSY
);

  localparam int IDX_W = idx_width(XFER_LEN);

  dma_state_e       state;
  dma_state_e       state_next;
  logic             parity;
  logic [7:0]       page;
  logic [7:0]       latch;
  logic             rdy_q;
  logic [IDX_W-1:0] idx;
  logic [7:0]       idx_lo;
  logic             idx_tc;
  logic             trigger;

  assign trigger = !CPU_RnW && (CPU_A == PAGE_REG);
  assign idx_lo  = 8'(idx);

  dma_byte_counter #(
    .LEN (XFER_LEN),
    .W   (IDX_W)
  ) u_counter (
    .clk      (PHI0),
    .rst      (RES),
    .clear    ((state == ST_WRITE) && idx_tc),
    .inc      (state == ST_WRITE),
    .count    (idx),
    .terminal (idx_tc)
  );

  // HALT waits out the core's pending writes; a parity-1 halt read costs one ALIGN cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (trigger) state_next = ST_HALT;
      ST_HALT:  if (CPU_RnW) state_next = parity ? ST_ALIGN : ST_READ;
      ST_ALIGN: state_next = ST_READ;
      ST_READ:  state_next = ST_WRITE;
      ST_WRITE: state_next = idx_tc ? ST_IDLE : ST_READ;
      default:  state_next = ST_IDLE;
    endcase
  end

  // RDY comes from its own flop so CPU_A has no combinational path to the pad.
  always_ff @(posedge PHI0) begin
    if (RES) begin
      state  <= ST_IDLE;
      parity <= 1'b0;
      page   <= 8'h00;
      latch  <= 8'h00;
      rdy_q  <= 1'b1;
    end else begin
      state  <= state_next;
      parity <= ~parity;
      rdy_q  <= (state_next == ST_IDLE);
      if ((state == ST_IDLE) && trigger) begin
        page <= CPU_DO;
      end
      if (state == ST_READ) begin
        latch <= BUS_DI;
      end
    end
  end

  always_comb begin
    BUS_A   = CPU_A;
    BUS_RnW = CPU_RnW;
    BUS_DO  = CPU_DO;
    case (state)
      ST_READ: begin
        BUS_A   = {page, idx_lo};
        BUS_RnW = 1'b1;
      end
      ST_WRITE: begin
        BUS_A   = DST_ADDR;
        BUS_RnW = 1'b0;
        BUS_DO  = latch;
      end
      default: ;
    endcase
  end

  assign RDY      = rdy_q;
  assign DMA_BUSY = (state != ST_IDLE);
  assign CPU_DI   = BUS_DI;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: a default 256-byte instance and a
// 4-byte instance share the core-side stimulus; expectations come from a queue.
module tb_oam_dma_ctrl;

  localparam logic [15:0] PAGE_A = 16'h4014;
  localparam logic [15:0] DST    = 16'h2004;
  localparam logic [15:0] HOLD_A = 16'hC5A3;
  localparam int          LEN_M  = 256;
  localparam int          LEN_S  = 4;

  typedef struct packed {
    logic        rdy;
    logic        busy;
    logic [15:0] a;
    logic        rnw;
    logic [7:0]  dout;
    logic [7:0]  di;
  } obs_t;

  typedef struct {
    logic        res;
    logic [15:0] a;
    logic        rnw;
    logic [7:0]  d;
    obs_t        exp_m;
    obs_t        exp_s;
    logic        care_m;
    logic        care_s;
    int          tag;
    int          t;
  } cyc_t;

  typedef struct {
    logic        res;
    logic [15:0] a;
    logic        rnw;
    logic [7:0]  d;
  } tv_t;

  logic        phi0 = 1'b0;
  logic        res;
  logic [15:0] cpu_a;
  logic        cpu_rnw;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di_m, cpu_di_s;
  logic        rdy_m, rdy_s;
  logic [15:0] bus_a_m, bus_a_s;
  logic        bus_rnw_m, bus_rnw_s;
  logic [7:0]  bus_do_m, bus_do_s;
  logic [7:0]  bus_di_m, bus_di_s;
  logic        busy_m, busy_s;

  cyc_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          par_cyc = 0;
  int          stall_m, stall_s, exp_stall_m, exp_stall_s;
  logic [15:0] ew_a[2];
  logic [7:0]  ew_d[2];
  tv_t         tv[10];

  always #5 phi0 = ~phi0;

  // Memory image: every address returns a distinct-looking byte.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ {a[10:8], a[15:11]} ^ 8'hA5;
  endfunction

  assign bus_di_m = mem(bus_a_m);
  assign bus_di_s = mem(bus_a_s);

  oam_dma_ctrl u_dut (
    .PHI0(phi0), .RES(res), .CPU_A(cpu_a), .CPU_RnW(cpu_rnw), .CPU_DO(cpu_do),
    .CPU_DI(cpu_di_m), .RDY(rdy_m), .BUS_A(bus_a_m), .BUS_RnW(bus_rnw_m),
    .BUS_DO(bus_do_m), .BUS_DI(bus_di_m), .DMA_BUSY(busy_m)
  );

  oam_dma_ctrl #(.XFER_LEN(LEN_S)) u_small (
    .PHI0(phi0), .RES(res), .CPU_A(cpu_a), .CPU_RnW(cpu_rnw), .CPU_DO(cpu_do),
    .CPU_DI(cpu_di_s), .RDY(rdy_s), .BUS_A(bus_a_s), .BUS_RnW(bus_rnw_s),
    .BUS_DO(bus_do_s), .BUS_DI(bus_di_s), .DMA_BUSY(busy_s)
  );

  function automatic obs_t pass_obs(input logic rdy, input logic busy, input logic [15:0] a,
                                    input logic rnw, input logic [7:0] d);
    obs_t o;
    o.rdy = rdy; o.busy = busy; o.a = a; o.rnw = rnw; o.dout = d; o.di = mem(a);
    return o;
  endfunction

  function automatic logic read_slot(input int len, input int t, input int prefix);
    int k;
    k = t - prefix;
    return (k >= 0) && (k < 2 * len) && (k % 2 == 0);
  endfunction

  // Cycle t of a burst: trigger at t=0, halt cycles up to prefix-1, then READ/WRITE pairs.
  function automatic obs_t expect_at(input int len, input int t, input int prefix,
                                     input logic [7:0] page, input logic [15:0] a,
                                     input logic rnw, input logic [7:0] d);
    int k;
    logic [7:0] i;
    k = t - prefix;
    if (t == 0) return pass_obs(1'b1, 1'b0, a, rnw, d);
    if (k < 0) return pass_obs(1'b0, 1'b1, a, rnw, d);
    if (k < 2 * len) begin
      i = 8'(k / 2);
      if (k % 2 == 0) return pass_obs(1'b0, 1'b1, {page, i}, 1'b1, 8'h00);
      return pass_obs(1'b0, 1'b1, DST, 1'b0, mem({page, i}));
    end
    return pass_obs(1'b1, 1'b0, a, rnw, d);
  endfunction

  task automatic check_output(input string name, input int tag, input int t,
                              input obs_t act, input obs_t exp, input logic care);
    obs_t m;
    m = '1;
    if (!care) m.dout = 8'h00;
    n_cmp++;
    if ((act & m) !== (exp & m)) begin
      n_bad++;
      $display("[TB] FAIL %s tag=%0d t=%0d got=%h want=%h", name, tag, t, act & m, exp & m);
    end
  endtask

  task automatic check_count(input string name, input int tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s tag=%0d got=%0d want=%0d", name, tag, act, exp);
    end
  endtask

  task automatic apply_stimulus(input cyc_t c);
    obs_t am, as_;
    res = c.res; cpu_a = c.a; cpu_rnw = c.rnw; cpu_do = c.d;
    @(negedge phi0);
    am  = {rdy_m, busy_m, bus_a_m, bus_rnw_m, bus_do_m, cpu_di_m};
    as_ = {rdy_s, busy_s, bus_a_s, bus_rnw_s, bus_do_s, cpu_di_s};
    check_output("main", c.tag, c.t, am, c.exp_m, c.care_m);
    check_output("len4", c.tag, c.t, as_, c.exp_s, c.care_s);
    if (rdy_m === 1'b0) stall_m++;
    if (rdy_s === 1'b0) stall_s++;
    @(posedge phi0);
    par_cyc = c.res ? 0 : par_cyc + 1;
    #1;
  endtask

  task automatic run_queue(input int tag);
    cyc_t c;
    stall_m = 0; stall_s = 0;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      apply_stimulus(c);
    end
    if (exp_stall_m >= 0) check_count("stall_main", tag, stall_m, exp_stall_m);
    if (exp_stall_s >= 0) check_count("stall_len4", tag, stall_s, exp_stall_s);
  endtask

  task automatic push_idle(input logic r, input logic [15:0] a, input logic rnw,
                           input logic [7:0] d, input int tag, input int t);
    cyc_t c;
    c.res = r; c.a = a; c.rnw = rnw; c.d = d;
    c.exp_m = pass_obs(1'b1, 1'b0, a, rnw, d);
    c.exp_s = c.exp_m;
    c.care_m = 1'b1; c.care_s = 1'b1; c.tag = tag; c.t = t;
    sb.push_back(c);
  endtask

  task automatic align_to(input int p);
    while ((par_cyc % 2) != p) begin
      push_idle(1'b0, HOLD_A, 1'b1, 8'h00, 0, par_cyc);
      exp_stall_m = -1; exp_stall_s = -1;
      run_queue(0);
    end
  endtask

  // Queue a whole burst: trigger, nw stretched core writes, held read, copy; abort_idx>=0 resets there.
  task automatic gen_burst(input int tag, input logic [7:0] page, input int nw, input int abort_idx);
    cyc_t c;
    int prefix, t_ab, last;
    logic algn;
    algn   = ((par_cyc + 1 + nw) % 2) == 1;
    prefix = nw + 2 + (algn ? 1 : 0);
    t_ab   = (abort_idx >= 0) ? prefix + 2 * abort_idx : -1;
    last   = (abort_idx >= 0) ? t_ab + 1 : prefix + 2 * LEN_M;
    for (int t = 0; t <= last; t++) begin
      if (t == 0) begin
        c.a = PAGE_A; c.rnw = 1'b0; c.d = page;
      end else if (t <= nw) begin
        c.a = ew_a[t-1]; c.rnw = 1'b0; c.d = ew_d[t-1];
      end else begin
        c.a = HOLD_A; c.rnw = 1'b1; c.d = 8'hEE;
      end
      c.res = (t == t_ab);
      if (t_ab >= 0 && t > t_ab) c.exp_m = pass_obs(1'b1, 1'b0, c.a, c.rnw, c.d);
      else c.exp_m = expect_at(LEN_M, t, prefix, page, c.a, c.rnw, c.d);
      c.exp_s  = expect_at(LEN_S, t, prefix, page, c.a, c.rnw, c.d);
      c.care_m = !read_slot(LEN_M, t, prefix);
      c.care_s = !read_slot(LEN_S, t, prefix);
      c.tag = tag; c.t = t;
      sb.push_back(c);
    end
    exp_stall_m = (abort_idx >= 0) ? -1 : prefix - 1 + 2 * LEN_M;
    exp_stall_s = prefix - 1 + 2 * LEN_S;
  endtask

  initial begin
    tv[0] = '{1'b0, 16'h0000, 1'b1, 8'h00};
    tv[1] = '{1'b0, 16'hFFFF, 1'b1, 8'h00};
    tv[2] = '{1'b0, 16'h4015, 1'b0, 8'h33};
    tv[3] = '{1'b0, 16'h4013, 1'b0, 8'h44};
    tv[4] = '{1'b0, 16'h4014, 1'b1, 8'h55};
    tv[5] = '{1'b1, 16'h4014, 1'b0, 8'h66};
    tv[6] = '{1'b0, 16'h8000, 1'b0, 8'hA5};
    tv[7] = '{1'b0, 16'h1234, 1'b1, 8'h5A};
    tv[8] = '{1'b0, 16'h2004, 1'b0, 8'hC3};
    tv[9] = '{1'b0, 16'h0200, 1'b1, 8'h00};
    ew_a[0] = 16'h01FD; ew_d[0] = 8'h12;
    ew_a[1] = PAGE_A;   ew_d[1] = 8'h05;

    res = 1'b1; cpu_a = 16'h0000; cpu_rnw = 1'b1; cpu_do = 8'h00;
    repeat (2) @(posedge phi0);
    par_cyc = 0;
    #1;

    $display("[TB] idle pass-through vectors");
    for (int i = 0; i < 10; i++) push_idle(tv[i].res, tv[i].a, tv[i].rnw, tv[i].d, 100, i);
    exp_stall_m = 0; exp_stall_s = 0;
    run_queue(100);

    $display("[TB] burst, halt read on parity 0");
    align_to(1);
    gen_burst(1, 8'h02, 0, -1);
    run_queue(1);

    $display("[TB] burst, halt read on parity 1");
    align_to(0);
    gen_burst(2, 8'h10, 0, -1);
    run_queue(2);

    $display("[TB] write-stretched halt with ignored re-trigger");
    gen_burst(3, 8'h02, 2, -1);
    run_queue(3);

    $display("[TB] reset mid-burst then fresh trigger");
    gen_burst(5, 8'h02, 0, 8'h40);
    run_queue(5);
    gen_burst(6, 8'h03, 0, -1);
    run_queue(6);

    $display("[TB] page 7F burst");
    gen_burst(7, 8'h7F, 0, -1);
    run_queue(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
